signature_frame_rx: RTL and testbench

- Byte-serial front end for the signature verifier.
- Receives framed signature packets from the host link (SOF byte, 4 payload bytes, XOR checksum byte) over a valid/ready byte interface.
- Assembles the 32-bit signature word, region byte first.
- Presents only checksum-good words to the verifier input register as a one-cycle sig_valid pulse, and keeps good-frame and error counters.

---
 rtl/sig_rx_pkg.sv | 25 ++
 rtl/sig_gap_timer.sv | 33 +++
 rtl/signature_frame_rx.sv | 149 ++++++++++++++
 tb/tb_signature_frame_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sig_rx_pkg.sv
// sig_rx_pkg: definitions shared by the signature frame receiver and the
// verifier decode stage.
//   state_t      - receiver FSM states
//   SOF_DEFAULT  - default start-of-frame marker byte
//   *_MSB        - bit offsets of each field inside the 32-bit signature word
//   sig_word_t   - the assembled signature word
package sig_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam int REGION_MSB = 31;
  localparam int AUTH_MSB   = 23;
  localparam int EXPIRY_MSB = 15;
  localparam int SIGID_MSB  = 7;

  typedef logic [31:0] sig_word_t;

endpackage

// File: rtl/sig_gap_timer.sv
// sig_gap_timer: counts consecutive cycles without a byte transfer while a
// frame is open.
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - zero the count (a transfer happened, or no frame is open)
//   enable       - frame open; count idle cycles
//   timeout_hit  - this idle cycle is the TIMEOUT_CYC-th in a row
module sig_gap_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout_hit
);

  logic [7:0] gap_cnt_reg;

  // Fires while the count is about to reach TIMEOUT_CYC, so a transfer in
  // that same cycle (which asserts clear) suppresses the timeout.
  assign timeout_hit = enable && !clear && (gap_cnt_reg == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_reg <= 8'd0;
    end else if (clear) begin
      gap_cnt_reg <= 8'd0;
    end else if (enable) begin
      gap_cnt_reg <= gap_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/signature_frame_rx.sv
// signature_frame_rx: byte-serial receiver for framed signature packets
// (SOF, region, auth_level, expiry, signature_id, XOR checksum).
//   clk, rst       - clock, asynchronous active-high reset
//   byte_in/valid  - incoming byte stream; byte_ready is the accept handshake
//   signature_out  - last checksum-good signature word
//   sig_valid      - one-cycle pulse when signature_out is updated
//   err_checksum   - one-cycle pulse, frame dropped on checksum mismatch
//   err_timeout    - one-cycle pulse, frame dropped on inter-byte gap
//   busy           - receiver is not idle
//   frame_ok_cnt   - saturating count of good frames
//   frame_err_cnt  - saturating count of dropped frames
module signature_frame_rx
  import sig_rx_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = 16,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      signature_out,
  output logic             sig_valid,
  output logic             err_checksum,
  output logic             err_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  state_t     state_reg;
  logic [1:0] idx_reg;
  logic [7:0] acc_reg;
  sig_word_t  word_reg;
  sig_word_t  sig_out_reg;
  logic       sig_valid_reg;
  logic       err_checksum_reg;
  logic       err_timeout_reg;
  logic [CNT_W-1:0] ok_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  logic xfer;
  logic timer_active;
  logic timeout_hit;
  logic csum_pass;

  assign byte_ready   = (state_reg != EMIT);
  assign busy         = (state_reg != IDLE);
  assign xfer         = byte_valid && byte_ready;
  assign timer_active = (state_reg == PAYLOAD) || (state_reg == CHECK);
  assign csum_pass    = (byte_in == acc_reg);

  assign signature_out = sig_out_reg;
  assign sig_valid     = sig_valid_reg;
  assign err_checksum  = err_checksum_reg;
  assign err_timeout   = err_timeout_reg;
  assign frame_ok_cnt  = ok_cnt_reg;
  assign frame_err_cnt = err_cnt_reg;

  // Timer is held clear outside PAYLOAD/CHECK, so it starts from zero on
  // every entry into PAYLOAD.
  sig_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (xfer || !timer_active),
    .enable     (timer_active),
    .timeout_hit(timeout_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= 2'd0;
      acc_reg          <= 8'd0;
      word_reg         <= '0;
      sig_out_reg      <= '0;
      sig_valid_reg    <= 1'b0;
      err_checksum_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;
      ok_cnt_reg       <= '0;
      err_cnt_reg      <= '0;
    end else begin
      sig_valid_reg    <= 1'b0;
      err_checksum_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          // Anything other than the marker is line noise, dropped silently.
          if (xfer && byte_in == SOF_BYTE) begin
            state_reg <= PAYLOAD;
            idx_reg   <= 2'd0;
            acc_reg   <= 8'd0;
          end
        end

        PAYLOAD: begin
          if (xfer) begin
            // SOF_BYTE is ordinary data here; there is no resync.
            unique case (idx_reg)
              2'd0: word_reg[REGION_MSB -: 8] <= byte_in;
              2'd1: word_reg[AUTH_MSB   -: 8] <= byte_in;
              2'd2: word_reg[EXPIRY_MSB -: 8] <= byte_in;
              2'd3: word_reg[SIGID_MSB  -: 8] <= byte_in;
            endcase
            acc_reg <= acc_reg ^ byte_in;
            idx_reg <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              state_reg <= CHECK;
            end
          end else if (timeout_hit) begin
            state_reg       <= IDLE;
            err_timeout_reg <= 1'b1;
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
          end
        end

        CHECK: begin
          // The verdict is registered at the checksum transfer so the pulse
          // and the counter update coincide with the EMIT cycle.
          if (xfer) begin
            state_reg <= EMIT;
            if (csum_pass) begin
              sig_valid_reg <= 1'b1;
              sig_out_reg   <= word_reg;
              if (ok_cnt_reg != '1) ok_cnt_reg <= ok_cnt_reg + 1'b1;
            end else begin
              err_checksum_reg <= 1'b1;
              if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
            end
          end else if (timeout_hit) begin
            state_reg       <= IDLE;
            err_timeout_reg <= 1'b1;
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
          end
        end

        EMIT: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signature_frame_rx.sv
module tb_signature_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] signature_out;
  logic        sig_valid;
  logic        err_checksum;
  logic        err_timeout;
  logic        busy;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  signature_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .signature_out(signature_out),
    .sig_valid    (sig_valid),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .busy         (busy),
    .frame_ok_cnt (frame_ok_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one byte, waiting (bounded) for byte_ready, then transfer it.
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 4 && !byte_ready; i++) tick();
    check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [7:0] cs);
    send(8'hA5);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
    send(cs);
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check("reset_sig_out", signature_out, 32'h0);
    check("reset_ready", {31'd0, byte_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ok_cnt", {16'd0, frame_ok_cnt}, 32'd0);
    check("reset_err_cnt", {16'd0, frame_err_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Bad checksum: 12^34^56^78 = 08, send 09.
    send_frame(32'h12345678, 8'h09);
    check("bad_cs_pulse", {31'd0, err_checksum}, 32'd1);
    check("bad_cs_no_valid", {31'd0, sig_valid}, 32'd0);
    check("bad_cs_err_cnt", {16'd0, frame_err_cnt}, 32'd1);
    check("bad_cs_sig_held", signature_out, 32'h0);
    check("bad_cs_ready_low", {31'd0, byte_ready}, 32'd0);

    // Good frame.
    send_frame(32'h12345678, 8'h08);
    check("good_valid", {31'd0, sig_valid}, 32'd1);
    check("good_sig", signature_out, 32'h12345678);
    check("good_ok_cnt", {16'd0, frame_ok_cnt}, 32'd1);
    check("good_ready_low", {31'd0, byte_ready}, 32'd0);
    tick();
    check("good_pulse_end", {31'd0, sig_valid}, 32'd0);
    check("good_idle", {31'd0, busy}, 32'd0);

    // Timeout: 16 idle cycles after the region byte.
    send(8'hA5);
    send(8'h12);
    idle(15);
    check("to_not_yet", {31'd0, err_timeout}, 32'd0);
    check("to_still_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("to_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_busy_low", {31'd0, busy}, 32'd0);
    check("to_err_cnt", {16'd0, frame_err_cnt}, 32'd2);
    tick();
    check("to_pulse_end", {31'd0, err_timeout}, 32'd0);
    send_frame(32'h12345678, 8'h08);
    check("after_to_valid", {31'd0, sig_valid}, 32'd1);
    check("after_to_ok_cnt", {16'd0, frame_ok_cnt}, 32'd2);

    // Leading noise bytes, then DEADBEEF (checksum 22).
    send(8'h00);
    check("noise00_busy", {31'd0, busy}, 32'd0);
    send(8'hFF);
    send(8'h3C);
    check("noise_busy", {31'd0, busy}, 32'd0);
    check("noise_err_cnt", {16'd0, frame_err_cnt}, 32'd2);
    send_frame(32'hDEADBEEF, 8'h22);
    check("dead_valid", {31'd0, sig_valid}, 32'd1);
    check("dead_sig", signature_out, 32'hDEADBEEF);
    check("dead_ok_cnt", {16'd0, frame_ok_cnt}, 32'd3);

    // 15-cycle gap does not time out; transfer lands in the threshold cycle.
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    idle(15);
    send(8'h56);
    check("gap15_no_to", {31'd0, err_timeout}, 32'd0);
    check("gap15_busy", {31'd0, busy}, 32'd1);
    send(8'h78);
    send(8'h08);
    check("gap15_valid", {31'd0, sig_valid}, 32'd1);
    check("gap15_sig", signature_out, 32'h12345678);
    check("gap15_ok_cnt", {16'd0, frame_ok_cnt}, 32'd4);
    check("gap15_err_cnt", {16'd0, frame_err_cnt}, 32'd2);
    tick();

    // Reset mid-frame.
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    rst = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_sig", signature_out, 32'h0);
    check("mrst_ok_cnt", {16'd0, frame_ok_cnt}, 32'd0);
    check("mrst_err_cnt", {16'd0, frame_err_cnt}, 32'd0);
    check("mrst_pulses", {29'd0, sig_valid, err_checksum, err_timeout}, 32'd0);
    tick();
    rst = 1'b0;
    send(8'h56);
    send(8'h78);
    send(8'h08);
    check("mrst_tail_busy", {31'd0, busy}, 32'd0);
    check("mrst_tail_pulses", {29'd0, sig_valid, err_checksum, err_timeout}, 32'd0);
    tick();
    check("mrst_tail_after", {29'd0, sig_valid, err_checksum, err_timeout}, 32'd0);
    send_frame(32'hDEADBEEF, 8'h22);
    check("mrst_fresh_valid", {31'd0, sig_valid}, 32'd1);
    check("mrst_fresh_sig", signature_out, 32'hDEADBEEF);
    check("mrst_fresh_ok_cnt", {16'd0, frame_ok_cnt}, 32'd1);
    check("mrst_fresh_err_cnt", {16'd0, frame_err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
